// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit: decodes one latched instruction into register-file, A/G and bus controls.
// Latency: done one cycle after the run-sample edge for mvi/mv/illegal, three cycles for ALU ops.
// Backpressure: none; run is sampled only in IDLE and ignored while busy.
module proc_ctrl_fsm #(
    parameter int NREGS  = 8,
    parameter int RSEL_W = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic [2:0]        func,
    input  logic [RSEL_W-1:0] rx,
    input  logic [RSEL_W-1:0] ry,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic              g_out,
    output logic [1:0]        alu_op,
    output logic [NREGS-1:0]  r_in,
    output logic [NREGS-1:0]  r_out
);

    localparam logic [2:0] OP_MVI = 3'b000;
    localparam logic [2:0] OP_MV  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        lat_func;
    logic [RSEL_W-1:0] lat_rx;
    logic [RSEL_W-1:0] lat_ry;

    // Decoded select of a register index; all-zero when the index is beyond NREGS,
    // which doubles as the out-of-range detector for that select.
    function automatic logic [NREGS-1:0] sel_onehot(input logic [RSEL_W-1:0] sel);
        logic [NREGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel == RSEL_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    logic [NREGS-1:0] rx_oh;
    logic [NREGS-1:0] ry_oh;
    logic             op_bad;
    logic             uses_ry;
    logic             is_ill;
    logic             is_alu;
    logic [1:0]       alu_code;

    // Instruction classification from the latched fields only
    always_comb begin
        rx_oh    = sel_onehot(lat_rx);
        ry_oh    = sel_onehot(lat_ry);
        op_bad   = (lat_func[2:1] == 2'b11);
        uses_ry  = (lat_func != OP_MVI);
        is_ill   = op_bad || (rx_oh == '0) || (uses_ry && (ry_oh == '0));
        is_alu   = (lat_func == OP_ADD) || (lat_func == OP_XOR) ||
                   (lat_func == OP_SUB) || (lat_func == OP_AND);
        case (lat_func)
            OP_SUB:  alu_code = 2'b01;
            OP_XOR:  alu_code = 2'b10;
            OP_AND:  alu_code = 2'b11;
            default: alu_code = 2'b00;
        endcase
    end

    // Step sequencing and instruction latch; fields are captured only on the IDLE run sample
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            lat_func <= '0;
            lat_rx   <= '0;
            lat_ry   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        lat_func <= func;
                        lat_rx   <= rx;
                        lat_ry   <= ry;
                        state    <= T1;
                    end
                end
                T1:      state <= (!is_ill && is_alu) ? T2 : IDLE;
                T2:      state <= T3;
                T3:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Control outputs decode straight from state and latch so reset clears them immediately
    always_comb begin
        busy    = (state != IDLE);
        done    = 1'b0;
        illegal = 1'b0;
        din_out = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        alu_op  = 2'b00;
        r_in    = '0;
        r_out   = '0;
        case (state)
            T1: begin
                if (is_ill) begin
                    done    = 1'b1;
                    illegal = 1'b1;
                end else if (lat_func == OP_MVI) begin
                    din_out = 1'b1;
                    r_in    = rx_oh;
                    done    = 1'b1;
                end else if (lat_func == OP_MV) begin
                    r_out   = ry_oh;
                    r_in    = rx_oh;
                    done    = 1'b1;
                end else begin
                    r_out   = rx_oh;
                    a_in    = 1'b1;
                end
            end
            T2: begin
                r_out  = ry_oh;
                g_in   = 1'b1;
                alu_op = alu_code;
            end
            T3: begin
                g_out = 1'b1;
                r_in  = rx_oh;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
